// File: rtl/cpu_pkg.sv
// Shared core types: data/address words, register selects, memory access
// modes and the load/store sequencer state encoding.
package cpu_pkg;

  typedef logic [31:0] cpu_word;
  typedef logic [31:0] pc_word;
  typedef logic [4:0]  reg_select;

  typedef enum logic [1:0] {
    MEM_W = 2'd0,
    MEM_H = 2'd1,
    MEM_B = 2'd2
  } mem_mode;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    LOAD_WAIT = 2'd1,
    STORE_RD  = 2'd2,
    STORE_WR  = 2'd3
  } lsu_state;

endpackage

// File: rtl/load_extend.sv
// Extends a right-justified load word from ram_unit to 32 bits according
// to the access width and signedness.
module load_extend
  import cpu_pkg::*;
(
  input  cpu_word word,
  input  mem_mode mode,
  input  logic    isSigned,
  output cpu_word result
);

  // ram_unit leaves stale upper bits on narrow reads, so they are always replaced.
  always_comb begin
    result = word;
    case (mode)
      MEM_H:   result = {{16{isSigned & word[15]}}, word[15:0]};
      MEM_B:   result = {{24{isSigned & word[7]}}, word[7:0]};
      default: result = word;
    endcase
  end

endmodule

// File: rtl/lsu_ctrl.sv
// Load/store sequencer in front of ram_unit port 2; stalls the PC while the
// RAM's read or read-modify-write sequence runs. Optional alignment trap
// is built when LSU_ALIGN_CHECK_EN is defined.
module lsu_ctrl
  import cpu_pkg::*;
#(
  parameter bit RESET_PC_ADV = 1'b1
) (
  input  logic      clk,
  input  logic      reset,
  input  logic      req_valid,
  output logic      req_ready,
  input  logic      req_write,
  input  cpu_word   req_addr,
  input  cpu_word   req_data,
  input  mem_mode   req_mode,
  input  logic      req_signed,
  input  reg_select req_rd,
  output logic      ram_en,
  output logic      ram_we,
  output cpu_word   ram_adr,
  output cpu_word   ram_wdata,
  output mem_mode   ram_mode,
  input  cpu_word   ram_rdata,
  input  logic      ram_avail,
  input  logic      ram_iavail,
  output logic      pc_advance,
  output logic      load_valid,
  output cpu_word   load_data,
  output reg_select load_rd,
  output logic      fault,
  output cpu_word   fault_addr
);

  lsu_state  state;
  mem_mode   ldMode;
  logic      ldSigned;
  reg_select ldRd;
  logic      accept;
  logic      misaligned;
  logic      ramFire;
  cpu_word   extWord;

`ifdef LSU_ALIGN_CHECK_EN
  assign misaligned = ((req_mode == MEM_W) && (req_addr[1:0] != 2'b00)) ||
                      ((req_mode == MEM_H) && req_addr[0]);
`else
  assign misaligned = 1'b0;
`endif

  // Reset gates acceptance so nothing reaches ram_unit while it is also in reset.
  assign req_ready = !reset && (state == IDLE) && ram_iavail;
  assign accept    = req_valid && req_ready;
  assign ramFire   = accept && !misaligned;

  always_comb begin
    ram_en    = ramFire;
    ram_we    = ramFire && req_write;
    ram_adr   = ramFire ? req_addr : '0;
    ram_wdata = ramFire ? req_data : '0;
    ram_mode  = ramFire ? req_mode : MEM_W;
  end

  assign pc_advance = reset ? RESET_PC_ADV : ((state == IDLE) && !accept);

  load_extend u_extend (
    .word    (ram_rdata),
    .mode    (ldMode),
    .isSigned(ldSigned),
    .result  (extWord)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      ldMode     <= MEM_W;
      ldSigned   <= 1'b0;
      ldRd       <= '0;
      load_valid <= 1'b0;
      load_data  <= '0;
      load_rd    <= '0;
    end else begin
      load_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (ramFire) begin
            if (req_write) begin
              state <= STORE_RD;
            end else begin
              state    <= LOAD_WAIT;
              ldMode   <= req_mode;
              ldSigned <= req_signed;
              ldRd     <= req_rd;
            end
          end
        end
        LOAD_WAIT: begin
          if (ram_avail) begin
            load_data  <= extWord;
            load_rd    <= ldRd;
            load_valid <= 1'b1;
            state      <= IDLE;
          end
        end
        // ram_unit reads then writes the word back; we only need to wait it out.
        STORE_RD: state <= STORE_WR;
        STORE_WR: state <= IDLE;
        default:  state <= IDLE;
      endcase
    end
  end

`ifdef LSU_ALIGN_CHECK_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      fault      <= 1'b0;
      fault_addr <= '0;
    end else begin
      fault <= accept && misaligned;
      if (accept && misaligned) begin
        fault_addr <= req_addr;
      end
    end
  end
`else
  assign fault      = 1'b0;
  assign fault_addr = '0;
`endif

endmodule

// File: tb/tb_lsu_ctrl.sv
// Scoreboard bench for lsu_ctrl with a behavioural ram_unit port-2 model
// and a byte-array reference memory.
module tb_lsu_ctrl;
  import cpu_pkg::*;

  logic      clk = 1'b0;
  logic      reset;
  logic      req_valid, req_ready, req_write, req_signed;
  cpu_word   req_addr, req_data;
  mem_mode   req_mode;
  reg_select req_rd;
  logic      ram_en, ram_we, ram_avail, ram_iavail;
  cpu_word   ram_adr, ram_wdata, ram_rdata;
  mem_mode   ram_mode;
  logic      pc_advance, load_valid, fault;
  cpu_word   load_data, fault_addr;
  reg_select load_rd;

  always #5 clk = ~clk;

  lsu_ctrl #(.RESET_PC_ADV(1'b1)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_data(req_data), .req_mode(req_mode),
    .req_signed(req_signed), .req_rd(req_rd),
    .ram_en(ram_en), .ram_we(ram_we), .ram_adr(ram_adr), .ram_wdata(ram_wdata),
    .ram_mode(ram_mode), .ram_rdata(ram_rdata), .ram_avail(ram_avail),
    .ram_iavail(ram_iavail), .pc_advance(pc_advance),
    .load_valid(load_valid), .load_data(load_data), .load_rd(load_rd),
    .fault(fault), .fault_addr(fault_addr)
  );

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int extraLat = 0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] initWord(int i);
    if (i == 0) return 32'h8081F0F1;
    return 32'h9E3779B9 * (i + 7);
  endfunction

  // ---------------- ram_unit port-2 model (words 0x100..0x1FF) ----------------
  logic [31:0] ramWords [64];
  bit          memInit = 1'b0;
  logic        pending;
  int          waitCnt;
  logic [31:0] rdHold, junk;

  function automatic logic [31:0] ramRead(logic [31:0] w, logic [31:0] a, mem_mode m);
    case (m)
      MEM_B:   return w >> (8 * a[1:0]);
      MEM_H:   return a[1] ? (w >> 16) : w;
      default: return w;
    endcase
  endfunction

  function automatic logic [31:0] ramMerge(logic [31:0] w, logic [31:0] a, mem_mode m, logic [31:0] d);
    logic [31:0] r;
    r = w;
    case (m)
      MEM_B:   r[8*a[1:0] +: 8]  = d[7:0];
      MEM_H:   r[16*a[1] +: 16]  = d[15:0];
      default: r = d;
    endcase
    return r;
  endfunction

  always @(posedge clk) begin
    junk <= $urandom;
    if (!memInit) begin
      for (int i = 0; i < 64; i++) ramWords[i] <= initWord(i);
      memInit <= 1'b1;
    end
    if (reset) begin
      pending   <= 1'b0;
      ram_avail <= 1'b0;
    end else begin
      ram_avail <= 1'b0;
      if (ram_en && !ram_we) begin
        rdHold <= ramRead(ramWords[ram_adr[7:2]], ram_adr, ram_mode);
        if (extraLat == 0) ram_avail <= 1'b1;
        else begin
          pending <= 1'b1;
          waitCnt <= extraLat;
        end
      end else if (pending) begin
        if (waitCnt == 1) begin
          ram_avail <= 1'b1;
          pending   <= 1'b0;
        end
        waitCnt <= waitCnt - 1;
      end
      if (ram_en && ram_we)
        ramWords[ram_adr[7:2]] <= ramMerge(ramWords[ram_adr[7:2]], ram_adr, ram_mode, ram_wdata);
    end
  end

  assign ram_rdata = ram_avail ? rdHold : junk;

  // ---------------- reference model ----------------
  logic [7:0] refMem [256];

  function automatic logic [31:0] refLoad(logic [31:0] addr, mem_mode m, logic sgn);
    int a, v;
    a = int'(addr[7:0]);
    case (m)
      MEM_H: begin
        a = a - (a % 2);
        v = int'(refMem[a]) + 256 * int'(refMem[a+1]);
        if (sgn && v >= 32768) v = v - 65536;
        return 32'(v);
      end
      MEM_B: begin
        v = int'(refMem[a]);
        if (sgn && v >= 128) v = v - 256;
        return 32'(v);
      end
      default: begin
        a = a - (a % 4);
        return {refMem[a+3], refMem[a+2], refMem[a+1], refMem[a]};
      end
    endcase
  endfunction

  task automatic refStore(logic [31:0] addr, mem_mode m, logic [31:0] d);
    int a, n;
    a = int'(addr[7:0]);
    n = (m == MEM_B) ? 1 : (m == MEM_H) ? 2 : 4;
    a = a - (a % n);
    for (int k = 0; k < n; k++) refMem[a+k] = d[8*k +: 8];
  endtask

  function automatic bit isMis(logic [31:0] addr, mem_mode m);
`ifdef LSU_ALIGN_CHECK_EN
    return ((m == MEM_W) && (addr[1:0] != 2'b00)) || ((m == MEM_H) && addr[0]);
`else
    return 1'b0;
`endif
  endfunction

  typedef struct { logic [31:0] data; logic [4:0] rd; int expCyc; } ld_exp_t;
  typedef struct { logic [31:0] addr; int expCyc; } ft_exp_t;
  ld_exp_t loadQ[$];
  ft_exp_t faultQ[$];

  task automatic check(string name, logic [31:0] act, logic [31:0] expv);
    total++;
    if (act !== expv) begin
      bad++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, expv, cyc);
    end
  endtask

  // ---------------- monitor ----------------
  always begin
    @(negedge clk);
    #2;
    if (!reset) begin
      if (load_valid) begin
        if (loadQ.size() == 0) begin
          total++; bad++;
          $display("FAIL unexpected_load_valid: got data %h rd %0d, none pending", load_data, load_rd);
        end else begin
          ld_exp_t e;
          e = loadQ.pop_front();
          $display("load done rd=%0d data=%h cycle=%0d", load_rd, load_data, cyc);
          check("load_data", load_data, e.data);
          check("load_rd", 32'(load_rd), 32'(e.rd));
          if (e.expCyc >= 0) check("load_latency", cyc, e.expCyc);
        end
      end
      if (fault) begin
        if (faultQ.size() == 0) begin
          total++; bad++;
          $display("FAIL unexpected_fault: got addr %h, none pending", fault_addr);
        end else begin
          ft_exp_t f;
          f = faultQ.pop_front();
          $display("fault addr=%h cycle=%0d", fault_addr, cyc);
          check("fault_addr", fault_addr, f.addr);
          check("fault_cycle", cyc, f.expCyc);
        end
      end
      if (ram_en && !ram_iavail) begin
        total++; bad++;
        $display("FAIL ram_en_without_iavail: got ram_en 1, expected 0");
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic doReq(input logic wr, input logic [31:0] addr, input logic [31:0] data,
                       input mem_mode m, input logic sgn, input logic [4:0] rd,
                       input bit randIavail, output int acc);
    int  tries;
    bit  mis, ok;
    tries = 0;
    ok = 1'b0;
    req_valid = 1'b1; req_write = wr; req_addr = addr; req_data = data;
    req_mode = m; req_signed = sgn; req_rd = rd;
    ram_iavail = randIavail ? ($urandom_range(0, 3) != 0) : 1'b1;
    #1;
    while (tries < 60) begin
      if (!ram_iavail) check("ready_without_iavail", 32'(req_ready), 32'd0);
      if (req_ready) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
      ram_iavail = randIavail ? ($urandom_range(0, 3) != 0) : 1'b1;
      #1;
      tries++;
    end
    acc = cyc;
    if (!ok) begin
      total++; bad++;
      $display("FAIL accept_timeout: got req_ready 0 for 60 cycles, expected 1");
    end else begin
      mis = isMis(addr, m);
      $display("req %0s addr=%h mode=%0d signed=%0d data=%h rd=%0d cycle=%0d",
               wr ? "ST" : "LD", addr, m, sgn, data, rd, cyc);
      check("accept_ram_en", 32'(ram_en), mis ? 32'd0 : 32'd1);
      check("accept_pc_advance", 32'(pc_advance), 32'd0);
      if (!mis) begin
        check("accept_ram_we", 32'(ram_we), 32'(wr));
        check("accept_ram_adr", ram_adr, addr);
        check("accept_ram_mode", 32'(ram_mode), 32'(m));
        check("accept_ram_wdata", ram_wdata, data);
      end
      if (mis) faultQ.push_back('{addr: addr, expCyc: cyc + 1});
      else if (wr) refStore(addr, m, data);
      else loadQ.push_back('{data: refLoad(addr, m, sgn), rd: rd,
                             expCyc: (extraLat == 0) ? cyc + 2 : -1});
    end
    @(negedge clk);
    req_valid = 1'b0;
    ram_iavail = 1'b1;
  endtask

  task automatic waitDrain();
    int n;
    n = 0;
    while ((loadQ.size() != 0 || faultQ.size() != 0) && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (n == 40) begin
      total++; bad++;
      $display("FAIL drain_timeout: got %0d loads %0d faults pending, expected 0",
               loadQ.size(), faultQ.size());
      loadQ.delete();
      faultQ.delete();
    end
    @(negedge clk);
  endtask

  initial begin
    int acc, acc2;
    logic [31:0] w;
    reset = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_addr = '0; req_data = '0;
    req_mode = MEM_W; req_signed = 1'b0; req_rd = '0; ram_iavail = 1'b1;
    for (int i = 0; i < 64; i++) begin
      w = initWord(i);
      for (int b = 0; b < 4; b++) refMem[4*i+b] = w[8*b +: 8];
    end

    repeat (3) @(negedge clk);
    #1;
    check("rst_pc_advance", 32'(pc_advance), 32'd1);
    check("rst_ram_en", 32'(ram_en), 32'd0);
    check("rst_ram_we", 32'(ram_we), 32'd0);
    check("rst_load_valid", 32'(load_valid), 32'd0);
    check("rst_load_data", load_data, 32'd0);
    check("rst_load_rd", 32'(load_rd), 32'd0);
    check("rst_fault", 32'(fault), 32'd0);
    check("rst_fault_addr", fault_addr, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    #1;
    check("idle_ready", 32'(req_ready), 32'd1);
    check("idle_pc_advance", 32'(pc_advance), 32'd1);

    // Signed byte load.
    doReq(1'b0, 32'h101, 32'h0, MEM_B, 1'b1, 5'd5, 1'b0, acc);
    waitDrain();

    // Unsigned half load; PC held in accept cycle and LOAD_WAIT.
    doReq(1'b0, 32'h102, 32'h0, MEM_H, 1'b0, 5'd9, 1'b0, acc);
    #1;
    check("lw_wait_pc_advance", 32'(pc_advance), 32'd0);
    check("lw_wait_ready", 32'(req_ready), 32'd0);
    waitDrain();

    // Byte store then word load.
    doReq(1'b1, 32'h103, 32'h55, MEM_B, 1'b0, 5'd0, 1'b0, acc);
    #1;
    check("st_rd_ready", 32'(req_ready), 32'd0);
    check("st_rd_pc_advance", 32'(pc_advance), 32'd0);
    @(negedge clk); #1;
    check("st_wr_ready", 32'(req_ready), 32'd0);
    check("st_wr_pc_advance", 32'(pc_advance), 32'd0);
    @(negedge clk); #1;
    check("st_done_ready", 32'(req_ready), 32'd1);
    doReq(1'b0, 32'h100, 32'h0, MEM_W, 1'b0, 5'd7, 1'b0, acc);
    waitDrain();

    // Misaligned word load.
    doReq(1'b0, 32'h102, 32'h0, MEM_W, 1'b0, 5'd3, 1'b0, acc);
    waitDrain();

    // Reset during STORE_RD; stored byte equals current contents.
    doReq(1'b1, 32'h100, {24'h0, refMem[0]}, MEM_B, 1'b0, 5'd0, 1'b0, acc);
    reset = 1'b1;
    #1;
    check("rst_mid_pc_advance", 32'(pc_advance), 32'd1);
    check("rst_mid_ram_en", 32'(ram_en), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    #1;
    check("rst_mid_ready", 32'(req_ready), 32'd1);
    repeat (3) @(negedge clk);

    // Reset during LOAD_WAIT suppresses the writeback.
    doReq(1'b0, 32'h104, 32'h0, MEM_W, 1'b0, 5'd4, 1'b0, acc);
    reset = 1'b1;
    void'(loadQ.pop_back());
    @(negedge clk);
    reset = 1'b0;
    repeat (3) @(negedge clk);

    // Back-to-back loads.
    doReq(1'b0, 32'h100, 32'h0, MEM_W, 1'b0, 5'd1, 1'b0, acc);
    doReq(1'b0, 32'h104, 32'h0, MEM_W, 1'b0, 5'd2, 1'b0, acc2);
    check("b2b_accept_gap", 32'(acc2 - acc), 32'd2);
    waitDrain();

    // Randomized traffic with variable RAM latency and fetch-state gaps.
    for (int t = 0; t < 200; t++) begin
      logic        wr, sg;
      mem_mode     m;
      logic [31:0] a;
      wr = 1'($urandom_range(0, 1));
      sg = 1'($urandom_range(0, 1));
      m  = mem_mode'($urandom_range(0, 2));
      a  = 32'h100 | 32'($urandom_range(0, 255));
      extraLat = $urandom_range(0, 2);
      doReq(wr, a, $urandom, m, sg, 5'($urandom_range(0, 31)), 1'b1, acc);
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end
    waitDrain();
    check("final_load_queue", 32'(loadQ.size()), 32'd0);
    check("final_fault_queue", 32'(faultQ.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
